// File: rtl/rf_writeback_pkg.sv
// ---------------------------------------------------------------------------
// rf_writeback_pkg
// Shared constants and types for the register-file writeback stage.
//   XLEN        : default result / write-data width
//   REG_ADDR_W  : register index width
//   NUM_REGS    : architectural register count (x0 is hardwired zero)
//   LQ_DEPTH    : default load-result queue depth (power of two, >= 2)
//   wb_entry_t  : one pending writeback {rd, data}
// ---------------------------------------------------------------------------
package rf_writeback_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int LQ_DEPTH   = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_load_fifo.sv
// ---------------------------------------------------------------------------
// wb_load_fifo
// Small FIFO holding load results that lost arbitration to the ALU.
// Ports:
//   clk, rst_n   : clock, async active-low reset (clears pointers and count)
//   push, push_data : enqueue (caller guarantees !full)
//   pop, pop_data   : dequeue; pop_data is the current head (valid when !empty)
//   full, empty, count : occupancy, all derived from the registered count
// ---------------------------------------------------------------------------
module wb_load_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);

endmodule

// File: rtl/rf_writeback.sv
// ---------------------------------------------------------------------------
// rf_writeback
// Writeback arbiter between an unstallable ALU and a queued load path, plus
// a pending-write scoreboard for operand hazard checks.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   alu_valid/alu_rd/alu_data     : ALU result, always wins arbitration
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : load result handshake into queue
//   iss_valid/iss_rd              : issuing instruction marks rd pending
//   qaddr1/qaddr2 -> busy1/busy2  : combinational scoreboard lookup
//   rf_wen/rf_waddr/rf_wdata      : registered register-file write port
// ---------------------------------------------------------------------------
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int XLEN     = rf_writeback_pkg::XLEN,
    parameter int LQ_DEPTH = rf_writeback_pkg::LQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] qaddr1,
    input  logic [REG_ADDR_W-1:0] qaddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int EW = REG_ADDR_W + XLEN;
    localparam int CW = $clog2(LQ_DEPTH) + 1;

    logic                  w_lq_full;
    logic                  w_lq_empty;
    logic [CW-1:0]         w_lq_count;
    logic [EW-1:0]         w_lq_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sel_valid;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_commit;
    logic [NUM_REGS-1:0]   w_pending_nxt;

    logic                  r_wen;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]       r_wdata;
    logic [NUM_REGS-1:0]   r_pending;

    // Ready comes only from the registered count, so it never depends on
    // alu_valid in the same cycle and reads 1 while the queue is reset.
    assign lsu_ready = (w_lq_count != CW'(LQ_DEPTH));
    assign w_push    = lsu_valid && !w_lq_full;
    assign w_pop     = !alu_valid && !w_lq_empty;

    wb_load_fifo #(
        .DW    (EW),
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({lsu_rd, lsu_data}),
        .pop       (w_pop),
        .pop_data  (w_lq_head),
        .full      (w_lq_full),
        .empty     (w_lq_empty),
        .count     (w_lq_count)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (!w_lq_empty) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = w_lq_head[EW-1:XLEN];
            w_sel_data  = w_lq_head[XLEN-1:0];
        end
    end

    // x0 results are consumed from their source but never written.
    assign w_commit = w_sel_valid && (w_sel_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_commit;
            if (w_commit) begin
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    // Clear first, then set, so a re-issue on the commit cycle keeps the bit.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_commit) w_pending_nxt[w_sel_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0)) w_pending_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_pending_nxt;
    end

    assign busy1    = (qaddr1 != '0) && r_pending[qaddr1];
    assign busy2    = (qaddr2 != '0) && r_pending[qaddr2];

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;
    import rf_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  qaddr1 = '0;
    logic [4:0]  qaddr2 = '0;
    logic        busy1, busy2;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .qaddr1(qaddr1), .qaddr2(qaddr2), .busy1(busy1), .busy2(busy2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of waiting loads, a pending bit per
    // register, and the last expected write-port contents.
    wb_entry_t   mq[$];
    logic [31:0] m_pend;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend  = '0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] q1, input logic [4:0] q2, output logic acc);
        wb_entry_t   e;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] sd;
        logic        er;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        iss_valid = iv; iss_rd = ird;
        qaddr1 = q1; qaddr2 = q2;
        #1;
        er = (mq.size() != LQ_DEPTH);
        check("lsu_ready", {63'd0, lsu_ready}, {63'd0, er});
        check("busy1", {63'd0, busy1}, {63'd0, (q1 != 0) && m_pend[q1]});
        check("busy2", {63'd0, busy2}, {63'd0, (q2 != 0) && m_pend[q2]});
        acc = lv && er;
        sv = 1'b0; srd = '0; sd = '0;
        if (av) begin
            sv = 1'b1; srd = ard; sd = ad;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            sv = 1'b1; srd = e.rd; sd = e.data;
        end
        if (acc) begin
            e.rd = lrd; e.data = ld;
            mq.push_back(e);
        end
        if (sv && srd != 0) begin
            m_wen = 1'b1; m_waddr = srd; m_wdata = sd;
            m_pend[srd] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        @(posedge clk);
        #1;
        check("rf_wen", {63'd0, rf_wen}, {63'd0, m_wen});
        check("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
        check("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
    endtask

    task automatic idle(input logic [4:0] q1, output logic acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, q1, 5'd0, acc);
    endtask

    initial begin
        logic        acc;
        int          k;
        logic [4:0]  ld_rd;
        logic [31:0] ld_d;
        logic        ld_pend;

        model_reset();
        qaddr1 = 5'd7;
        #12;
        check("rst_wen", {63'd0, rf_wen}, 64'd0);
        check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        check("rst_ready", {63'd0, lsu_ready}, 64'd1);
        check("rst_busy1", {63'd0, busy1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);
        check("alu_only_wen", {63'd0, rf_wen}, 64'd1);
        check("alu_only_addr", {59'd0, rf_waddr}, 64'd5);
        check("alu_only_data", {32'd0, rf_wdata}, 64'hDEADBEEF);

        // Contention: ALU first, load one cycle later
        cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, acc);
        check("cont_alu_addr", {59'd0, rf_waddr}, 64'd3);
        idle(5'd0, acc);
        check("cont_ld_addr", {59'd0, rf_waddr}, 64'd4);
        check("cont_ld_data", {32'd0, rf_wdata}, 64'h22);

        // x0 destination is dropped; issue to x0 marks nothing
        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, acc);
        check("x0_wen", {63'd0, rf_wen}, 64'd0);
        idle(5'd0, acc);

        // Backpressure: ALU stream of 4 while 3 loads are offered
        k = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(c < 4, 5'(10 + c), 32'hA000 + c, k < 3, 5'(20 + k), 32'hB000 + k,
                1'b0, 5'd0, 5'd0, 5'd0, acc);
            if (acc) k++;
            if (c == 2) check("bp_ready_low", {63'd0, lsu_ready}, 64'd0);
        end
        check("bp_all_accepted", 64'(k), 64'd3);

        // Scoreboard set / clear / re-issue on commit cycle
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, acc);
        idle(5'd7, acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd7, acc);
        idle(5'd7, acc);
        idle(5'd7, acc);
        check("sb_cleared", {63'd0, busy1}, 64'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 5'd7, 5'd0, acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, acc);
        idle(5'd7, acc);
        check("sb_reissue", {63'd0, busy1}, 64'd1);

        // Reset mid-operation with two loads queued
        cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9, 1'b1, 5'd12, 5'd0, 5'd0, acc);
        cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 5'd0, 5'd0, acc);
        #2;
        rst_n = 1'b0;
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0; qaddr1 = 5'd12;
        #1;
        check("mid_rst_wen", {63'd0, rf_wen}, 64'd0);
        check("mid_rst_ready", {63'd0, lsu_ready}, 64'd1);
        check("mid_rst_waddr", {59'd0, rf_waddr}, 64'd0);
        check("mid_rst_busy", {63'd0, busy1}, 64'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) idle(5'd9, acc);

        // Randomized traffic; an offered load is held until accepted
        ld_pend = 1'b0; ld_rd = '0; ld_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!ld_pend && ($urandom_range(0, 2) != 0)) begin
                ld_pend = 1'b1;
                ld_rd = 5'($urandom_range(0, 31));
                ld_d = $urandom;
            end
            cyc($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                ld_pend, ld_rd, ld_d,
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), acc);
            if (acc) ld_pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
